// File: rtl/cpu_run_pkg.sv
// Shared types for the 6502 run/halt/single-step sequencer.
//   run_state_t  : sequencer state (HALT, RUN, STEP)
//   halt_cause_t : why the sequencer last entered HALT
package cpu_run_pkg;

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } run_state_t;

  typedef logic [1:0] halt_cause_t;

  localparam halt_cause_t CAUSE_RESET = 2'b00;
  localparam halt_cause_t CAUSE_BTN   = 2'b01;
  localparam halt_cause_t CAUSE_STEP  = 2'b10;
  localparam halt_cause_t CAUSE_BP    = 2'b11;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted 0->1 transition.
//   clk, rst_n : clock, async active-low reset
//   btn        : raw button level, asynchronous to clk
//   press      : one-cycle pulse, 2 + 2^DEBOUNCE_BITS cycles after a clean press
module btn_debounce #(
  parameter int unsigned DEBOUNCE_BITS = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic                     sync1_q;
  logic                     sync2_q;
  logic                     level_q;
  logic [DEBOUNCE_BITS-1:0] cnt_q;

  // Count while the synchronized level disagrees with the accepted one;
  // any return to agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      press   <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == '1) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        press   <= sync2_q;
      end else begin
        cnt_q <= cnt_q + DEBOUNCE_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctl.sv
// Run/halt/single-step sequencer producing the core clock enable.
//   clk, rst_n          : 12 MHz clock, async active-low reset
//   btn_run, btn_step   : raw board buttons (asynchronous)
//   fetch_cycle, pc     : core is at opcode fetch / current program counter
//   bp_en, bp_addr      : static PC breakpoint
//   cpu_ce              : one-cycle enable pulse to the core
//   halted, halt_cause  : HALT indication and reason of last halt
//   cycle_count         : cpu_ce pulses issued
//   instr_count         : cpu_ce pulses issued at opcode fetch
module cpu_run_ctl
  import cpu_run_pkg::*;
#(
  parameter int unsigned DEBOUNCE_BITS = 17,
  parameter int unsigned DIV_BITS      = 0,
  parameter int unsigned CNT_W         = 32,
  parameter bit          START_RUN     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             fetch_cycle,
  input  logic [15:0]      pc,
  input  logic             bp_en,
  input  logic [15:0]      bp_addr,
  output logic             cpu_ce,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam run_state_t RESET_STATE = START_RUN ? RUN : HALT;

  logic        run_p;
  logic        step_p;
  logic        tick;
  logic        bp_hit;
  logic        step_done;
  run_state_t  state_q, state_nx;
  halt_cause_t cause_nx;
  logic        bp_skip_q, skip_nx;
  logic        step_seen_q, seen_nx;
  logic        ce_nx;

  btn_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_run_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_run),
    .press (run_p)
  );

  btn_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_step_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_step),
    .press (step_p)
  );

  // Run-rate divider: tick when the free-running count is all ones.
  generate
    if (DIV_BITS == 0) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      logic [DIV_BITS-1:0] div_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_q + DIV_BITS'(1);
      end
      assign tick = &div_q;
    end
  endgenerate

  // bp_skip lets the instruction at the breakpoint run once after a resume.
  assign bp_hit = bp_en & fetch_cycle & (pc == bp_addr) & ~bp_skip_q & tick
                & (state_q == RUN);

  // In STEP, the first fetch tick after an issued pulse parks the core.
  assign step_done = step_seen_q & fetch_cycle & tick;

  // Next state, halt reason and enable decision.
  always_comb begin
    state_nx = state_q;
    cause_nx = halt_cause_t'(halt_cause);
    skip_nx  = bp_skip_q;
    seen_nx  = step_seen_q;
    ce_nx    = 1'b0;
    case (state_q)
      HALT: begin
        if (run_p) begin
          state_nx = RUN;
          skip_nx  = 1'b1;
        end else if (step_p) begin
          state_nx = STEP;
          skip_nx  = 1'b1;
          seen_nx  = 1'b0;
        end
      end
      RUN: begin
        ce_nx = tick & ~bp_hit;
        if (run_p) begin
          state_nx = HALT;
          cause_nx = CAUSE_BTN;
        end else if (bp_hit) begin
          state_nx = HALT;
          cause_nx = CAUSE_BP;
        end
      end
      STEP: begin
        ce_nx = tick & ~step_done;
        if (ce_nx) seen_nx = 1'b1;
        if (run_p) begin
          state_nx = RUN;
        end else if (step_done) begin
          state_nx = HALT;
          cause_nx = CAUSE_STEP;
        end
      end
      default: state_nx = HALT;
    endcase
    if (ce_nx && fetch_cycle) skip_nx = 1'b0;
  end

  // State register and registered outputs; counters move with cpu_ce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      bp_skip_q   <= 1'b1;
      step_seen_q <= 1'b0;
      cpu_ce      <= 1'b0;
      halted      <= ~START_RUN;
      halt_cause  <= CAUSE_RESET;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state_q     <= state_nx;
      bp_skip_q   <= skip_nx;
      step_seen_q <= seen_nx;
      cpu_ce      <= ce_nx;
      halted      <= (state_nx == HALT);
      halt_cause  <= cause_nx;
      if (ce_nx) begin
        cycle_count <= cycle_count + CNT_W'(1);
        if (fetch_cycle) instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctl.sv
// Directed bench: instance A (no divider) covers debounce, run toggle,
// button simultaneity and reset; instance B (divide by 4) covers rate,
// single step and breakpoint with a 3-cycle-per-instruction core model.
module tb_cpu_run_ctl;
  import cpu_run_pkg::*;

  logic        clk;
  logic        rst_n;

  logic        btn_run_a, btn_step_a, fetch_a, bp_en_a;
  logic [15:0] pc_a, bp_addr_a;
  logic        cpu_ce_a, halted_a;
  logic [1:0]  cause_a;
  logic [31:0] cyc_a, ins_a;

  logic        btn_run_b, btn_step_b, fetch_b, bp_en_b;
  logic [15:0] pc_b, bp_addr_b;
  logic        cpu_ce_b, halted_b;
  logic [1:0]  cause_b;
  logic [31:0] cyc_b, ins_b;

  int vectors;
  int miscompares;
  int phase;

  cpu_run_ctl #(.DEBOUNCE_BITS(3), .DIV_BITS(0), .CNT_W(32), .START_RUN(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .btn_run(btn_run_a), .btn_step(btn_step_a),
    .fetch_cycle(fetch_a), .pc(pc_a), .bp_en(bp_en_a), .bp_addr(bp_addr_a),
    .cpu_ce(cpu_ce_a), .halted(halted_a), .halt_cause(cause_a),
    .cycle_count(cyc_a), .instr_count(ins_a)
  );

  cpu_run_ctl #(.DEBOUNCE_BITS(3), .DIV_BITS(2), .CNT_W(32), .START_RUN(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .btn_run(btn_run_b), .btn_step(btn_step_b),
    .fetch_cycle(fetch_b), .pc(pc_b), .bp_en(bp_en_b), .bp_addr(bp_addr_b),
    .cpu_ce(cpu_ce_b), .halted(halted_b), .halt_cause(cause_b),
    .cycle_count(cyc_b), .instr_count(ins_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the core model for B advances one micro-cycle per enable.
  task automatic cyc();
    logic ce;
    ce = cpu_ce_b;
    @(posedge clk);
    #1;
    if (ce) begin
      if (phase == 2) begin
        phase = 0;
        pc_b  = pc_b + 16'd2;
      end else begin
        phase++;
      end
    end
    fetch_b = (phase == 0);
  endtask

  initial begin
    int          pulses, last, bad;
    bit          seen_run, done;
    logic [31:0] c0, i0;

    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    btn_run_a = 1'b0; btn_step_a = 1'b0; fetch_a = 1'b0; pc_a = 16'h0000;
    bp_en_a = 1'b0; bp_addr_a = 16'h0000;
    btn_run_b = 1'b0; btn_step_b = 1'b0; bp_en_b = 1'b0; bp_addr_b = 16'h0204;
    phase = 0; pc_b = 16'h0200; fetch_b = 1'b1;

    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    chk("rst_halted", 32'(halted_a), 1);
    chk("rst_cause", 32'(cause_a), 32'(CAUSE_RESET));
    chk("rst_ce", 32'(cpu_ce_a), 0);
    chk("rst_cycles", cyc_a, 0);
    chk("rst_instr", ins_a, 0);

    // 5-cycle glitch is shorter than the 8-cycle stability window.
    btn_run_a = 1'b1;
    repeat (5) cyc();
    btn_run_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (cpu_ce_a || !halted_a) bad++;
    end
    chk("glitch_ignored", 32'(bad), 0);
    chk("glitch_cycles", cyc_a, 0);

    // Clean press: pulse after 10 edges, RUN after 11, first enable after 12.
    btn_run_a = 1'b1;
    repeat (10) cyc();
    chk("press_not_early", 32'(halted_a), 1);
    cyc();
    chk("run_entered", 32'(halted_a), 0);
    chk("run_no_ce_yet", 32'(cpu_ce_a), 0);
    cyc();
    chk("first_ce", 32'(cpu_ce_a), 1);
    chk("first_count", cyc_a, 1);
    chk("run_cause_kept", 32'(cause_a), 32'(CAUSE_RESET));
    btn_run_a = 1'b0;

    // Asynchronous reset in the middle of a run.
    for (int n = 0; n < 100 && cyc_a != 32'd37; n++) cyc();
    chk("reach_37", cyc_a, 37);
    rst_n = 1'b0;
    #1;
    chk("midrst_cycles", cyc_a, 0);
    chk("midrst_instr", ins_a, 0);
    chk("midrst_ce", 32'(cpu_ce_a), 0);
    chk("midrst_halted", 32'(halted_a), 1);
    chk("midrst_cause", 32'(cause_a), 32'(CAUSE_RESET));
    cyc();
    chk("midrst_ce_held", 32'(cpu_ce_a), 0);
    rst_n = 1'b1;
    cyc();

    // Run toggle: start, then stop with the RUN button.
    btn_run_a = 1'b1;
    repeat (11) cyc();
    chk("toggle_start", 32'(halted_a), 0);
    cyc();
    btn_run_a = 1'b0;
    repeat (15) cyc();
    btn_run_a = 1'b1;
    repeat (10) cyc();
    chk("toggle_still_run", 32'(halted_a), 0);
    cyc();
    chk("toggle_halt", 32'(halted_a), 1);
    chk("toggle_cause", 32'(cause_a), 32'(CAUSE_BTN));
    cyc();
    chk("toggle_ce_off", 32'(cpu_ce_a), 0);
    btn_run_a = 1'b0;
    repeat (15) cyc();

    // Both buttons together from HALT: RUN wins.
    btn_run_a = 1'b1; btn_step_a = 1'b1;
    repeat (11) cyc();
    chk("both_run", 32'(halted_a), 0);
    chk("both_cause_kept", 32'(cause_a), 32'(CAUSE_BTN));
    cyc();
    btn_run_a = 1'b0; btn_step_a = 1'b0;
    repeat (15) cyc();

    // STEP while running is ignored.
    btn_step_a = 1'b1;
    repeat (12) cyc();
    btn_step_a = 1'b0;
    repeat (15) cyc();
    chk("step_in_run_halted", 32'(halted_a), 0);
    chk("step_in_run_ce", 32'(cpu_ce_a), 1);

    // Divider: 40 cycles of RUN give 10 pulses 4 cycles apart.
    btn_run_b = 1'b1;
    repeat (12) cyc();
    btn_run_b = 1'b0;
    chk("div_running", 32'(halted_b), 0);
    c0 = cyc_b; pulses = 0; last = -1; bad = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (cpu_ce_b) begin
        if (last >= 0 && i - last != 4) bad++;
        last = i;
        pulses++;
      end
    end
    chk("div_pulses", 32'(pulses), 10);
    chk("div_spacing", 32'(bad), 0);
    chk("div_count", cyc_b - c0, 10);
    btn_run_b = 1'b1;
    repeat (12) cyc();
    btn_run_b = 1'b0;
    chk("div_stop", 32'(halted_b), 1);
    repeat (15) cyc();

    // Single step from a fetch: three enables, then park at the next fetch.
    phase = 0; pc_b = 16'h0200; fetch_b = 1'b1;
    c0 = cyc_b; i0 = ins_b; pulses = 0; seen_run = 1'b0; done = 1'b0;
    btn_step_b = 1'b1;
    for (int n = 0; n < 80 && !done; n++) begin
      cyc();
      if (n == 11) btn_step_b = 1'b0;
      if (cpu_ce_b) pulses++;
      if (!halted_b) seen_run = 1'b1;
      else if (seen_run) done = 1'b1;
    end
    btn_step_b = 1'b0;
    chk("step_halted", 32'(done), 1);
    chk("step_pulses", 32'(pulses), 3);
    chk("step_cause", 32'(cause_b), 32'(CAUSE_STEP));
    chk("step_instr", ins_b - i0, 1);
    chk("step_cycles", cyc_b - c0, 3);
    chk("step_parked_pc", 32'(pc_b), 32'h0202);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (cpu_ce_b) bad++;
    end
    chk("step_quiet", 32'(bad), 0);

    // Breakpoint at 0204: 0200 and 0202 execute, 0204 fetch is withheld.
    phase = 0; pc_b = 16'h0200; fetch_b = 1'b1; bp_en_b = 1'b1;
    i0 = ins_b; pulses = 0; seen_run = 1'b0; done = 1'b0;
    btn_run_b = 1'b1;
    for (int n = 0; n < 80 && !done; n++) begin
      cyc();
      if (n == 11) btn_run_b = 1'b0;
      if (cpu_ce_b) pulses++;
      if (!halted_b) seen_run = 1'b1;
      else if (seen_run) done = 1'b1;
    end
    btn_run_b = 1'b0;
    chk("bp_halted", 32'(done), 1);
    chk("bp_pulses", 32'(pulses), 6);
    chk("bp_cause", 32'(cause_b), 32'(CAUSE_BP));
    chk("bp_pc", 32'(pc_b), 32'h0204);
    chk("bp_instr", ins_b - i0, 2);
    repeat (15) cyc();

    // Resume at the breakpoint: 0204 runs once, no re-halt.
    i0 = ins_b; pulses = 0;
    btn_run_b = 1'b1;
    for (int n = 0; n < 80 && pulses < 3; n++) begin
      cyc();
      if (n == 11) btn_run_b = 1'b0;
      if (cpu_ce_b) pulses++;
    end
    btn_run_b = 1'b0;
    chk("resume_pulses", 32'(pulses), 3);
    chk("resume_running", 32'(halted_b), 0);
    chk("resume_instr", ins_b - i0, 1);
    cyc();
    chk("resume_next_pc", 32'(pc_b), 32'h0206);
    repeat (8) cyc();
    chk("resume_no_rehalt", 32'(halted_b), 0);
    chk("resume_cause_kept", 32'(cause_b), 32'(CAUSE_BP));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
